// File: rtl/tile_game_ctrl.sv
// Game-flow controller for the tile-sort game: button conditioning, phase
// sequencing (banner, scramble, play, win) and one-command-per-frame issue
// toward the tile datapath over a valid/ready handshake.
module tile_game_ctrl #(
  parameter int DB_W             = 20,
  parameter int DB_COUNT         = 500000,
  parameter int WIN_HOLD_FRAMES  = 120,
  parameter int WIN_FLASH_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  input  logic       frame_tick,
  input  logic       scramble_done,
  input  logic       sorted,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       scramble_start,
  output logic       show_banner,
  output logic       tiles_enable,
  output logic       win_flash,
  output logic [7:0] move_count,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    ST_BANNER   = 2'b00,
    ST_SCRAMBLE = 2'b01,
    ST_PLAY     = 2'b10,
    ST_WIN      = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_COUNT - 1);
  localparam logic [7:0]      HOLD_LAST  = 8'(WIN_HOLD_FRAMES - 1);
  localparam logic [7:0]      FLASH_LAST = 8'(WIN_FLASH_FRAMES - 1);

  logic [4:0]      r_sync1, r_sync2, r_db, r_db_d;
  logic [DB_W-1:0] r_db_cnt [5];
  logic [4:0]      w_press;

  state_t     r_state, w_state_nx;
  logic [4:0] r_pending, w_pending_nx, w_pend_set;
  logic       r_cmd_valid, w_cmd_valid_nx;
  logic [2:0] r_cmd_code, w_cmd_code_nx;
  logic       r_scramble_start, w_scramble_start_nx;
  logic       r_show_banner, r_tiles_enable;
  logic       r_win_flash, w_win_flash_nx;
  logic [7:0] r_move_count, w_move_count_nx;
  logic [7:0] r_frame_cnt, w_frame_cnt_nx;
  logic [7:0] r_flash_cnt, w_flash_cnt_nx;

  // Fixed priority pick: center > up > down > left > right; code = bit index + 1.
  function automatic logic [2:0] f_pick(input logic [4:0] p);
    if (p[1])      return 3'd2;
    else if (p[0]) return 3'd1;
    else if (p[2]) return 3'd3;
    else if (p[3]) return 3'd4;
    else if (p[4]) return 3'd5;
    else           return 3'd0;
  endfunction

  // One-hot pending bit owned by a command code.
  function automatic logic [4:0] f_mask(input logic [2:0] code);
    case (code)
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b01000;
      3'd5:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  // Two-flop synchronizer, then per-button debounce counter and level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 5'b0;
      r_sync2 <= 5'b0;
      r_db    <= 5'b0;
      r_db_d  <= 5'b0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A press is the cycle right after a debounced 0->1 flip.
  assign w_press    = r_db & ~r_db_d;
  assign w_pend_set = r_pending | w_press;

  // Next-state and next-output logic for the game phases.
  always_comb begin
    w_state_nx          = r_state;
    w_pending_nx        = r_pending;
    w_cmd_valid_nx      = r_cmd_valid;
    w_cmd_code_nx       = r_cmd_code;
    w_scramble_start_nx = 1'b0;
    w_win_flash_nx      = r_win_flash;
    w_move_count_nx     = r_move_count;
    w_frame_cnt_nx      = r_frame_cnt;
    w_flash_cnt_nx      = r_flash_cnt;
    case (r_state)
      ST_BANNER: begin
        w_pending_nx = 5'b0;
        if (w_press[1]) begin
          w_state_nx          = ST_SCRAMBLE;
          w_scramble_start_nx = 1'b1;
          w_move_count_nx     = 8'd0;
        end else begin
          w_state_nx = ST_BANNER;
        end
      end
      ST_SCRAMBLE: begin
        w_pending_nx = 5'b0;
        if (scramble_done) w_state_nx = ST_PLAY;
        else               w_state_nx = ST_SCRAMBLE;
      end
      ST_PLAY: begin
        if (r_cmd_valid) begin
          // Outstanding command: only the handshake matters; ticks are ignored.
          if (cmd_ready) begin
            w_cmd_valid_nx = 1'b0;
            w_cmd_code_nx  = 3'd0;
            w_pending_nx   = w_pend_set & ~f_mask(r_cmd_code);
            if ((r_cmd_code != 3'd2) && (r_move_count != 8'd255))
              w_move_count_nx = r_move_count + 8'd1;
            else
              w_move_count_nx = r_move_count;
          end else begin
            w_pending_nx = w_pend_set;
          end
        end else if (frame_tick && sorted) begin
          w_state_nx     = ST_WIN;
          w_pending_nx   = 5'b0;
          w_frame_cnt_nx = 8'd0;
          w_flash_cnt_nx = 8'd0;
          w_win_flash_nx = 1'b0;
        end else if (frame_tick && (r_pending != 5'b0)) begin
          w_cmd_valid_nx = 1'b1;
          w_cmd_code_nx  = f_pick(r_pending);
          w_pending_nx   = w_pend_set;
        end else begin
          w_pending_nx = w_pend_set;
        end
      end
      ST_WIN: begin
        w_pending_nx = 5'b0;
        if (frame_tick) begin
          if (r_frame_cnt == HOLD_LAST) begin
            w_state_nx     = ST_BANNER;
            w_win_flash_nx = 1'b0;
            w_frame_cnt_nx = 8'd0;
            w_flash_cnt_nx = 8'd0;
          end else begin
            w_frame_cnt_nx = r_frame_cnt + 8'd1;
            if (r_flash_cnt == FLASH_LAST) begin
              w_win_flash_nx = ~r_win_flash;
              w_flash_cnt_nx = 8'd0;
            end else begin
              w_flash_cnt_nx = r_flash_cnt + 8'd1;
            end
          end
        end else begin
          w_state_nx = ST_WIN;
        end
      end
      default: begin
        w_state_nx     = ST_BANNER;
        w_pending_nx   = 5'b0;
        w_cmd_valid_nx = 1'b0;
        w_cmd_code_nx  = 3'd0;
      end
    endcase
  end

  // State and registered outputs; layer enables are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_BANNER;
      r_pending        <= 5'b0;
      r_cmd_valid      <= 1'b0;
      r_cmd_code       <= 3'd0;
      r_scramble_start <= 1'b0;
      r_show_banner    <= 1'b1;
      r_tiles_enable   <= 1'b0;
      r_win_flash      <= 1'b0;
      r_move_count     <= 8'd0;
      r_frame_cnt      <= 8'd0;
      r_flash_cnt      <= 8'd0;
    end else begin
      r_state          <= w_state_nx;
      r_pending        <= w_pending_nx;
      r_cmd_valid      <= w_cmd_valid_nx;
      r_cmd_code       <= w_cmd_code_nx;
      r_scramble_start <= w_scramble_start_nx;
      r_show_banner    <= (w_state_nx == ST_BANNER);
      r_tiles_enable   <= (w_state_nx != ST_BANNER);
      r_win_flash      <= w_win_flash_nx;
      r_move_count     <= w_move_count_nx;
      r_frame_cnt      <= w_frame_cnt_nx;
      r_flash_cnt      <= w_flash_cnt_nx;
    end
  end

  assign cmd_valid      = r_cmd_valid;
  assign cmd_code       = r_cmd_code;
  assign scramble_start = r_scramble_start;
  assign show_banner    = r_show_banner;
  assign tiles_enable   = r_tiles_enable;
  assign win_flash      = r_win_flash;
  assign move_count     = r_move_count;
  assign game_state     = r_state;

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Scoreboard bench for tile_game_ctrl: expected command/move-count pairs are
// queued as buttons are pressed and checked by a monitor at each handshake.
module tb_tile_game_ctrl;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = 5'b0;
  logic       frame_tick = 1'b0, scramble_done = 1'b0, sorted = 1'b0, cmd_ready = 1'b0;
  logic       cmd_valid, scramble_start, show_banner, tiles_enable, win_flash;
  logic [2:0] cmd_code;
  logic [7:0] move_count;
  logic [1:0] game_state;

  tile_game_ctrl #(.DB_W(8), .DB_COUNT(DB), .WIN_HOLD_FRAMES(4), .WIN_FLASH_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .frame_tick(frame_tick),
    .scramble_done(scramble_done), .sorted(sorted), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .scramble_start(scramble_start),
    .show_banner(show_banner), .tiles_enable(tiles_enable), .win_flash(win_flash),
    .move_count(move_count), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int count; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0, cyc = 0, exp_moves = 0;
  int   up_events = 0, up_last_cyc = 0, sc_cnt = 0;
  bit   mon_cnt_chk = 1'b0, mon_hold = 1'b0;
  int   mon_cnt_exp = 0, mon_code = 0;

  task automatic check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Debounced up-press events and scramble_start pulse width.
  always @(negedge clk) begin
    if (rst_n && dut.w_press[0]) begin
      up_events++;
      up_last_cyc = cyc;
    end
    if (scramble_start) sc_cnt++;
  end

  // Scoreboard monitor: stability while stalled, code at handshake, count after.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt_chk = 1'b0;
      mon_hold    = 1'b0;
    end else begin
      if (mon_cnt_chk) begin
        check("move_count_after_hs", move_count, mon_cnt_exp);
        mon_cnt_chk = 1'b0;
      end
      if (mon_hold) check("cmd_stable", cmd_valid ? int'(cmd_code) : 9, mon_code);
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_handshake: got code %0d, expected no command", cmd_code);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_code", cmd_code, mon_e.code);
          mon_cnt_chk = 1'b1;
          mon_cnt_exp = mon_e.count;
        end
      end
      mon_hold = cmd_valid && !cmd_ready;
      mon_code = cmd_code;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic press(input logic [4:0] m);
    btn_raw = m;
    repeat (DB + 6) step();
    btn_raw = 5'b0;
    repeat (DB + 6) step();
  endtask

  // Reference: pressed buttons are served in priority order; non-select moves count.
  task automatic expect_mask(input logic [4:0] m);
    int ord [5] = '{1, 0, 2, 3, 4};
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      if (m[ord[k]]) begin
        e.code = ord[k] + 1;
        if (e.code != 2 && exp_moves < 255) exp_moves++;
        e.count = exp_moves;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int budget = 600;
    while (exp_q.size() != 0 && budget > 0) begin
      cmd_ready  = ($urandom_range(0, 1) == 1);
      frame_tick = ($urandom_range(0, 3) == 0);
      step();
      budget--;
    end
    frame_tick = 1'b0;
    cmd_ready  = 1'b0;
    repeat (2) step();
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d queued, expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, game_state, 0);
    check({tag, "_banner"}, show_banner, 1);
    check({tag, "_tiles"}, tiles_enable, 0);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_code"}, cmd_code, 0);
    check({tag, "_sstart"}, scramble_start, 0);
    check({tag, "_flash"}, win_flash, 0);
    check({tag, "_moves"}, move_count, 0);
  endtask

  task automatic start_game();
    press(5'b00010);
    exp_moves = 0;
    scramble_done = 1'b1;
    step();
    scramble_done = 1'b0;
    step();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [4:0] m;
    repeat (3) step();
    check_reset("rst");
    rst_n = 1'b1;
    step();

    // Debounce: 3-cycle glitch is rejected, stable press gives one event.
    btn_raw = 5'b00001;
    repeat (3) step();
    btn_raw = 5'b0;
    repeat (12) step();
    check("glitch_events", up_events, 0);
    btn_raw = 5'b00001;
    c0 = cyc;
    repeat (10) step();
    btn_raw = 5'b0;
    repeat (12) step();
    check("stable_events", up_events, 1);
    check("press_latency", up_last_cyc - c0, DB + 2);

    // Banner: left ignored, center starts the scramble.
    press(5'b01000);
    check("left_in_banner", game_state, 0);
    sc_cnt = 0;
    press(5'b00010);
    exp_moves = 0;
    check("scramble_state", game_state, 1);
    check("sstart_width", sc_cnt, 1);
    check("scramble_moves", move_count, 0);
    check("scramble_banner", show_banner, 0);
    check("scramble_tiles", tiles_enable, 1);
    scramble_done = 1'b1;
    step();
    scramble_done = 1'b0;
    check("play_state", game_state, 2);

    // Up + right together: up first, stalled for 5 cycles, then right.
    expect_mask(5'b10001);
    press(5'b10001);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", cmd_valid, 1);
      check("stall_code", cmd_code, 1);
      step();
    end
    drain();
    check("moves_two", move_count, 2);

    // Select with ready tied high does not count.
    cmd_ready = 1'b1;
    expect_mask(5'b00010);
    press(5'b00010);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    cmd_ready = 1'b0;
    check("select_drained", exp_q.size(), 0);
    check("select_moves", move_count, 2);

    // Random button combinations against the reference.
    for (int it = 0; it < 40; it++) begin
      m = 5'($urandom_range(1, 31));
      expect_mask(m);
      press(m);
      drain();
    end

    // Saturation.
    for (int it = 0; it < 256; it++) begin
      expect_mask(5'b01000);
      press(5'b01000);
      drain();
    end
    check("moves_saturated", move_count, 255);

    // Win entry deferred until the outstanding command completes.
    expect_mask(5'b00100);
    press(5'b00100);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("win_cmd_valid", cmd_valid, 1);
    sorted = 1'b1;
    tick();
    check("sorted_while_busy", game_state, 2);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    check("after_accept_state", game_state, 2);
    check("after_accept_valid", cmd_valid, 0);
    tick();
    sorted = 1'b0;
    check("win_state", game_state, 3);
    check("win_flash0", win_flash, 0);
    check("win_tiles", tiles_enable, 1);
    check("win_banner", show_banner, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("win_hold_state", game_state, 3);
      check("win_flash", win_flash, k % 2);
    end
    tick();
    check("win_exit_state", game_state, 0);
    check("win_exit_flash", win_flash, 0);
    check("win_exit_banner", show_banner, 1);
    check("win_moves_held", move_count, exp_moves);

    // Reset while a command is outstanding.
    start_game();
    check("replay_state", game_state, 2);
    expect_mask(5'b00001);
    press(5'b00001);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("pre_reset_valid", cmd_valid, 1);
    rst_n = 1'b0;
    #2;
    check_reset("midrst");
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_state", game_state, 0);
    check("post_reset_banner", show_banner, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
